// File: rtl/zind_seq_pkg.sv
// Shared definitions for the z-index sequencer and its consumers:
// FSM state encoding and default index/step widths.
package zind_seq_pkg;

    localparam int ZIND_ZW = 6;
    localparam int ZIND_SW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } zind_state_t;

endpackage

// File: rtl/zind_step_add.sv
// Combinational index + step adder with one extra carry bit so that
// the caller can detect a step past the top of the index range.
module zind_step_add #(
    parameter int ZW = 6,
    parameter int SW = 3
) (
    input  logic [ZW-1:0] z,
    input  logic [SW-1:0] step,
    output logic [ZW:0]   sum
);

    assign sum = {1'b0, z} + {{(ZW + 1 - SW){1'b0}}, step};

endmodule

// File: rtl/zind_seq.sv
// Programmable start/end/step z-index sequencer with valid/ready output,
// last-of-pass flag, optional looping, stop and abort.
module zind_seq
    import zind_seq_pkg::*;
#(
    parameter int ZW = ZIND_ZW,
    parameter int SW = ZIND_SW
) (
    input  logic          clk,
    input  logic          rst_a,
    input  logic          start_i,
    input  logic [ZW-1:0] zstart_i,
    input  logic [ZW-1:0] zend_i,
    input  logic [SW-1:0] step_i,
    input  logic          loop_i,
    input  logic          stop_i,
    input  logic          abort_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [ZW-1:0] zind_o,
    output logic          last_o,
    output logic          busy_o,
    output logic          done_o,
    output zind_state_t   dbg_state
);

    // Handshake: a transfer happens on a rising clk edge where valid_o and
    // ready_i are both 1. valid_o, zind_o and last_o never depend on ready_i
    // combinationally and stay stable until the transfer occurs.

    zind_state_t   state, state_nxt;
    logic [ZW-1:0] z;
    logic [ZW-1:0] zstart_q;
    logic [ZW-1:0] zend_q;
    logic [SW-1:0] step_q;
    logic          loop_q;
    logic [ZW:0]   nxt;
    logic          load;
    logic          advance;
    logic          rewind;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;

    zind_step_add #(
        .ZW (ZW),
        .SW (SW)
    ) u_step_add (
        .z    (z),
        .step (step_q),
        .sum  (nxt)
    );

    // Compare in ZW+1 bits so a step past 2^ZW-1 ends the pass instead of wrapping.
    assign last_o = (state == ST_RUN) &&
                    ((nxt > {1'b0, zend_q}) || (zstart_q > zend_q));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        rewind    = 1'b0;
        if (abort_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state_nxt = ST_RUN;
                        load      = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ready_i) begin
                        if (!last_o) begin
                            advance = 1'b1;
                        end else if (loop_q && !stop_i) begin
                            rewind = 1'b1;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_q <= (state_nxt == ST_RUN);
            busy_q  <= (state_nxt != ST_IDLE);
            done_q  <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            z        <= '0;
            zstart_q <= '0;
            zend_q   <= '0;
            step_q   <= '0;
            loop_q   <= 1'b0;
        end else if (load) begin
            z        <= zstart_i;
            zstart_q <= zstart_i;
            zend_q   <= zend_i;
            step_q   <= (step_i == '0) ? SW'(1) : step_i;
            loop_q   <= loop_i;
        end else if (advance) begin
            z <= nxt[ZW-1:0];
        end else if (rewind) begin
            z <= zstart_q;
        end
    end

    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign zind_o    = z;
    assign dbg_state = state;

endmodule

// File: tb/tb_zind_seq.sv
// Randomized and directed checks of zind_seq against a pass-list reference model.
module tb_zind_seq;
    import zind_seq_pkg::*;

    localparam int ZW = 6;
    localparam int SW = 3;

    logic          clk;
    logic          rst_a;
    logic          start_i;
    logic [ZW-1:0] zstart_i;
    logic [ZW-1:0] zend_i;
    logic [SW-1:0] step_i;
    logic          loop_i;
    logic          stop_i;
    logic          abort_i;
    logic          ready_i;
    logic          valid_o;
    logic [ZW-1:0] zind_o;
    logic          last_o;
    logic          busy_o;
    logic          done_o;
    zind_state_t   dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_seen = 0;
    int xfer_cyc[$];
    logic [ZW:0] exp_q[$];

    logic          hold_pend = 1'b0;
    logic          prev_last = 1'b0;
    logic [ZW-1:0] prev_z = '0;
    logic          prev_abort = 1'b0;
    logic          prev_acc_last = 1'b0;

    zind_seq #(.ZW(ZW), .SW(SW)) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .start_i   (start_i),
        .zstart_i  (zstart_i),
        .zend_i    (zend_i),
        .step_i    (step_i),
        .loop_i    (loop_i),
        .stop_i    (stop_i),
        .abort_i   (abort_i),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .zind_o    (zind_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: act=%0d req=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: list every index of one pass with its last flag.
    task automatic push_pass(input int zs, input int ze, input int st, input int limit);
        int v;
        int s;
        int n;
        logic last;
        logic [ZW:0] ent;
        s = (st == 0) ? 1 : st;
        n = 0;
        if (zs > ze) begin
            ent = {1'b1, ZW'(zs)};
            exp_q.push_back(ent);
        end else begin
            v = zs;
            while (1) begin
                last = ((v + s) > ze);
                if (limit < 0 || n < limit) begin
                    ent = {last, ZW'(v)};
                    exp_q.push_back(ent);
                end
                n++;
                if (last) break;
                v = v + s;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int zs, input int ze, input int st, input logic lp);
        int s;
        s = (st == 0) ? 1 : st;
        zstart_i = ZW'(zs);
        zend_i   = ZW'(ze);
        step_i   = SW'(st);
        loop_i   = lp;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        zstart_i = ZW'($urandom_range(0, 63));
        zend_i   = ZW'($urandom_range(0, 63));
        step_i   = SW'($urandom_range(0, 7));
        loop_i   = 1'(($urandom_range(0, 1)));
        check("start_valid", int'(valid_o), 1);
        check("start_busy", int'(busy_o), 1);
        check("start_zind", int'(zind_o), zs);
        check("start_last", int'(last_o), int'((zs > ze) || (zs + s > ze)));
    endtask

    // mode 0: ready always 1, 1: toggle 1/0, 2: random
    task automatic run_until_done(input int mode, input int bound);
        int d0;
        int i;
        d0 = done_seen;
        for (i = 0; i < bound; i++) begin
            if (mode == 0) ready_i = 1'b1;
            else if (mode == 1) ready_i = (i % 2 == 0);
            else ready_i = 1'(($urandom_range(0, 1)));
            tick();
            if (done_seen > d0) break;
        end
        ready_i = 1'b0;
        check("done_count", done_seen - d0, 1);
        check("idle_busy", int'(busy_o), 0);
        check("idle_done", int'(done_o), 0);
        check("idle_valid", int'(valid_o), 0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [ZW:0] e;
        logic acc;
        if (!rst_a) begin
            hold_pend     = 1'b0;
            prev_acc_last = 1'b0;
            prev_abort    = 1'b0;
        end else begin
            if (hold_pend && !prev_abort) begin
                check("hold_valid", int'(valid_o), 1);
                check("hold_zind", int'(zind_o), int'(prev_z));
                check("hold_last", int'(last_o), int'(prev_last));
            end
            if (done_o) begin
                done_seen++;
                check("done_after_last", int'(prev_acc_last), 1);
                check("done_busy", int'(busy_o), 1);
                check("done_valid", int'(valid_o), 0);
            end
            acc = valid_o && ready_i;
            if (acc) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: act=%0d req=none", zind_o);
                end else begin
                    e = exp_q.pop_front();
                    check("zind", int'(zind_o), int'(e[ZW-1:0]));
                    check("last", int'(last_o), int'(e[ZW]));
                end
            end
            prev_acc_last = acc && last_o;
            hold_pend     = valid_o && !ready_i;
            prev_last     = last_o;
            prev_z        = zind_o;
            prev_abort    = abort_i;
        end
    end

    initial begin
        int n0;
        int i;
        int zs;
        int ze;
        int st;
        int d0;
        rst_a = 1'b0;
        start_i = 1'b0; zstart_i = '0; zend_i = '0; step_i = '0;
        loop_i = 1'b0; stop_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
        repeat (3) tick();
        check("rst_valid", int'(valid_o), 0);
        check("rst_zind", int'(zind_o), 0);
        check("rst_last", int'(last_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        rst_a = 1'b1;
        tick();

        // one-shot contiguous, no bubbles
        push_pass(0, 5, 1, -1);
        n0 = xfer_cyc.size();
        do_start(0, 5, 1, 1'b0);
        run_until_done(0, 40);
        if (xfer_cyc.size() >= n0 + 6) check("contig_gap", xfer_cyc[n0 + 5] - xfer_cyc[n0], 5);
        else check("contig_count", xfer_cyc.size() - n0, 6);

        // stride with back-pressure, plus a start ignored mid-run
        push_pass(2, 20, 5, -1);
        do_start(2, 20, 5, 1'b0);
        zstart_i = 6'd50; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        run_until_done(1, 60);

        // top-of-range overflow
        push_pass(60, 63, 3, -1);
        do_start(60, 63, 3, 1'b0);
        run_until_done(2, 100);
        push_pass(60, 62, 3, -1);
        do_start(60, 62, 3, 1'b0);
        run_until_done(2, 100);

        // loop, then stop during the second pass
        push_pass(1, 3, 1, -1);
        push_pass(1, 3, 1, -1);
        n0 = xfer_cyc.size();
        ready_i = 1'b1;
        do_start(1, 3, 1, 1'b1);
        for (i = 0; i < 20 && xfer_cyc.size() < n0 + 4; i++) tick();
        check("loop_reach", int'(xfer_cyc.size() >= n0 + 4), 1);
        stop_i = 1'b1;
        run_until_done(0, 20);
        stop_i = 1'b0;
        if (xfer_cyc.size() >= n0 + 6) check("loop_gap", xfer_cyc[n0 + 5] - xfer_cyc[n0], 5);
        else check("loop_count", xfer_cyc.size() - n0, 6);

        // abort while presenting index 4
        push_pass(0, 10, 2, 2);
        ready_i = 1'b1;
        do_start(0, 10, 2, 1'b0);
        for (i = 0; i < 20 && !(valid_o && zind_o == 6'd4); i++) tick();
        check("abort_at4", int'(zind_o), 4);
        ready_i = 1'b0;
        abort_i = 1'b1;
        d0 = done_seen;
        tick();
        abort_i = 1'b0;
        check("abort_valid", int'(valid_o), 0);
        check("abort_busy", int'(busy_o), 0);
        repeat (3) tick();
        check("abort_no_done", done_seen - d0, 0);
        check("abort_q_empty", exp_q.size(), 0);

        // degenerate range, step 0
        push_pass(9, 4, 0, -1);
        do_start(9, 4, 0, 1'b0);
        run_until_done(2, 40);

        // reset mid-run
        push_pass(0, 7, 1, -1);
        ready_i = 1'b1;
        do_start(0, 7, 1, 1'b0);
        for (i = 0; i < 20 && !(valid_o && zind_o == 6'd3); i++) tick();
        rst_a = 1'b0;
        #1;
        check("mrst_valid", int'(valid_o), 0);
        check("mrst_zind", int'(zind_o), 0);
        check("mrst_last", int'(last_o), 0);
        check("mrst_busy", int'(busy_o), 0);
        check("mrst_done", int'(done_o), 0);
        exp_q.delete();
        ready_i = 1'b0;
        start_i = 1'b1; zstart_i = 6'd5;
        repeat (2) tick();
        check("mrst_start_ignored", int'(busy_o), 0);
        start_i = 1'b0;
        rst_a = 1'b1;
        tick();
        check("post_rst_busy", int'(busy_o), 0);
        push_pass(0, 2, 1, -1);
        do_start(0, 2, 1, 1'b0);
        run_until_done(0, 20);

        // random single passes
        for (int k = 0; k < 25; k++) begin
            zs = $urandom_range(0, 63);
            ze = $urandom_range(0, 63);
            st = $urandom_range(0, 7);
            push_pass(zs, ze, st, -1);
            stop_i = 1'b1;
            do_start(zs, ze, st, 1'(($urandom_range(0, 1))));
            run_until_done(2, 400);
            stop_i = 1'b0;
        end

        tick();
        check("final_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zind_seq.md
# zind_seq

Parametrised z-index sequencer that replaces the fixed +1 z-index increment with a programmable start/end/step walk. It emits a stream of z indexes under a valid/ready handshake, flags the last index of each pass and optionally loops. The block sits between the core controller, which programs and starts it, and the datapath stage that consumes one z index per accepted transfer.

## Interface
Parameters:
- ZW, 6, z-index width in bits
- SW, 3, step width in bits (step range 1..2^SW-1)

Ports:
- clk  in  1  system clock, rising edge
- rst_a  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start request, sampled only in IDLE
- zstart_i  in  ZW  first index of a pass, latched on start
- zend_i  in  ZW  inclusive upper bound, latched on start
- step_i  in  SW  increment, latched on start; 0 treated as 1
- loop_i  in  1  0 = one-shot, 1 = loop passes until stop, latched on start
- stop_i  in  1  level; in loop mode, end after the current pass
- abort_i  in  1  one-cycle abort, any state
- ready_i  in  1  consumer accepts zind_o this cycle
- valid_o  out  1  zind_o is valid
- zind_o  out  ZW  current z index
- last_o  out  1  zind_o is the final index of the pass (qualified by valid_o)
- busy_o  out  1  sequencer not in IDLE
- done_o  out  1  one-cycle pulse: sequence completed normally

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_i=1 latches zstart_i, zend_i, step_i (0 becomes 1) and loop_i; loads z=zstart; enters RUN.
- RUN: valid_o=1, zind_o=z. Next index is computed in ZW+1 bits: nxt = {0,z} + step. last_o = (nxt > {0,zend}) or (zstart > zend).
- Handshake: z advances only when valid_o && ready_i. zind_o and last_o are held stable while ready_i=0.
- Accept with last_o=0: z <= nxt[ZW-1:0].
- Accept with last_o=1: if loop=1 and stop_i=0, z <= zstart and RUN continues; otherwise the FSM goes to DONE.
- DONE: lasts one cycle, done_o=1, valid_o=0, then IDLE.
- abort_i: from any state, the next state is IDLE. valid_o is 0 the following cycle and no done_o pulse is produced. abort_i has priority over start_i and over the handshake.
- start_i outside IDLE is ignored. Register inputs are ignored outside the start cycle.
- zstart > zend: a pass is the single index zstart with last_o=1.
- Overflow: nxt beyond 2^ZW-1 is caught by the ZW+1-bit compare. The index never wraps silently.

## Timing
- Reset values: valid_o=0, zind_o=0, last_o=0, busy_o=0, done_o=0; FSM in IDLE.
- Start latency: valid_o rises the cycle after start_i is sampled.
- Throughput: one index per cycle while ready_i=1. No bubble on a loop wrap.
- done_o is asserted the cycle after the accepted last transfer, and busy_o falls one cycle after that.
- All outputs are registered. last_o may be a registered compare or a compare from registered state only; there is no combinational path from ready_i to any output.
- Reset asserted mid-sequence clears all state immediately. The first start after reset release behaves as from power-up.

## Structure
- A shared package holds the FSM state encoding (IDLE, RUN, DONE) and the default ZW/SW constants used by the z-index consumers.
- One sub-module: zind_step_add. It is combinational, takes a ZW-bit index and an SW-bit step, and returns the ZW+1-bit sum. It generalises the fixed +1 adder and is instantiated once.
- FSM and index registers live in the top module.

## Test plan
- One-shot, contiguous: zstart=0, zend=5, step=1, loop=0, ready_i=1 -> zind_o 0,1,2,3,4,5 on consecutive cycles; last_o only with 5; done_o pulse the next cycle.
- Stride with back-pressure: zstart=2, zend=20, step=5, ready_i toggling 1/0 -> indexes 2,7,12,17, each held while ready_i=0; last_o with 17.
- Top-of-range overflow: ZW=6, zstart=60, zend=63, step=3 -> indexes 60,63 with last_o on 63. Then zend=62 with the same start and step -> 60 only, with last_o; never 63 and never a wrap to 0.
- Loop and stop: zstart=1, zend=3, step=1, loop=1 -> 1,2,3,1,2,3,... with no gap. Raise stop_i during the second pass -> the sequence ends after that pass's 3, then done_o.
- Abort and degenerate range: abort_i while valid_o=1 at index 4 -> valid_o=0 next cycle, no done_o, busy_o=0. Then start with zstart=9, zend=4, step=0 -> single index 9 with last_o, then done_o.
- Reset mid-run: assert rst_a low at index 3 -> all outputs 0 immediately. Release, then start_i ignored until sampled in IDLE.
